spi_master16: RTL and testbench

- 16-bit full-duplex SPI master for an ADC128S-class serial A/D converter.
- One `wrt` pulse sends a 16-bit `cmd` on MOSI while capturing 16 bits from MISO. The captured word is presented on `rd_data`, and `done` flags completion.
- The ADC128S returns the conversion for the channel requested in the previous frame. Command format is `{2'b00, chnl[2:0], 11'h000}`.
- Sits between control logic and the off-chip A/D converter.

---
 rtl/spi_master16_pkg.sv | 17 +
 rtl/spi_master16_if.sv | 25 ++
 rtl/spi_master16.sv | 76 +++++++
 tb/tb_spi_master16.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/spi_master16_pkg.sv
// Shared constants and state encoding for the 16-bit SPI master.
// SCLK is the MSB of a free-running divider, so the sample/shift points are divider values.
package spi_pkg;

  localparam int               DIV_W    = 5;
  localparam logic [DIV_W-1:0] FRONT_LD = 5'b10111;
  localparam logic [DIV_W-1:0] SMPL_PT  = 5'b01111;
  localparam logic [DIV_W-1:0] SHFT_PT  = 5'b11111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    SHIFT = 2'd2,
    BACK  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_master16_if.sv
// Host handshake plus SPI pins of the A/D link, bundled for the master and its environment.
interface spi_master16_if;

  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  // master: the SPI master block itself
  modport master (
    input  wrt, cmd, MISO,
    output done, rd_data, SS_n, SCLK, MOSI
  );

  // slave: control logic and the off-chip converter around it
  modport slave (
    output wrt, cmd, MISO,
    input  done, rd_data, SS_n, SCLK, MOSI
  );

endinterface

// File: rtl/spi_master16.sv
// 16-bit full-duplex SPI master (SCLK idles high, MISO sampled on SCLK rise).
// One wrt pulse runs a frame of 16 SCLK cycles; done stays set until the next wrt.
module spi_master16
  import spi_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    spi_master16_if.master bus
);

    spi_state_e       r_state;
    logic [DIV_W-1:0] r_sclk_div;
    logic [15:0]      r_shft;
    logic             r_smpl;
    logic [3:0]       r_bcnt;
    logic             r_ss_n;
    logic             r_done;

    assign bus.SCLK    = r_sclk_div[DIV_W-1];
    assign bus.MOSI    = r_shft[15];
    assign bus.SS_n    = r_ss_n;
    assign bus.done    = r_done;
    assign bus.rd_data = r_shft;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sclk_div <= FRONT_LD;
            r_shft     <= 16'h0000;
            r_smpl     <= 1'b0;
            r_bcnt     <= 4'd0;
            r_ss_n     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_sclk_div <= FRONT_LD;
                    if (bus.wrt) begin
                        r_shft  <= bus.cmd;
                        r_ss_n  <= 1'b0;
                        r_done  <= 1'b0;
                        r_bcnt  <= 4'd0;
                        r_state <= FRONT;
                    end
                end
                FRONT: begin
                    r_sclk_div <= r_sclk_div + 1'b1;
                    if (r_sclk_div == SHFT_PT)
                        r_state <= SHIFT;
                end
                SHIFT: begin
                    r_sclk_div <= r_sclk_div + 1'b1;
                    if (r_sclk_div == SMPL_PT)
                        r_smpl <= bus.MISO;
                    if (r_sclk_div == SHFT_PT) begin
                        r_shft <= {r_shft[14:0], r_smpl};
                        r_bcnt <= r_bcnt + 4'd1;
                        // Last bit: park SCLK high so no 17th falling edge appears
                        if (r_bcnt == 4'd15) begin
                            r_sclk_div <= FRONT_LD;
                            r_ss_n     <= 1'b1;
                            r_state    <= BACK;
                        end
                    end
                end
                BACK: begin
                    r_sclk_div <= FRONT_LD;
                    r_done     <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master16.sv
// Directed bench for spi_master16 with a small ADC128S-style slave model and a loopback path.
module tb_spi_master16;

    logic clk;
    logic rst_n;
    logic loop;
    logic adc_miso;

    spi_master16_if bus();

    spi_master16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.MISO = loop ? bus.MOSI : adc_miso;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // ADC model: returns base+previous channel, base drops 0x10 after every second frame
    logic [11:0] adc_base = 12'hC00;
    logic [2:0]  adc_prev = 3'd0;
    logic [15:0] adc_tx   = 16'h0;
    logic [15:0] adc_rx   = 16'h0;
    int          adc_idx  = 0;
    int          adc_frames = 0;
    logic        adc_active = 1'b0;

    initial adc_miso = 1'b0;

    always @(negedge bus.SS_n) begin
        adc_tx     = {4'h0, adc_base + {9'd0, adc_prev}};
        adc_idx    = 0;
        adc_active = 1'b1;
    end

    always @(negedge bus.SCLK) begin
        if (!bus.SS_n && adc_idx < 16) begin
            adc_miso = adc_tx[15-adc_idx];
            adc_idx++;
        end
    end

    always @(posedge bus.SS_n) begin
        if (adc_active) begin
            adc_active = 1'b0;
            adc_prev   = adc_rx[13:11];
            adc_frames++;
            if (adc_frames % 2 == 0) adc_base = adc_base - 12'h010;
        end
    end

    // SCLK monitor: rise count, MOSI capture and rise timestamps
    int          rise_cnt = 0;
    logic [15:0] mosi_cap = 16'h0;
    time         t_last = 0;
    time         t_prev = 0;

    always @(posedge bus.SCLK) begin
        if (bus.SS_n === 1'b0) begin
            rise_cnt++;
            mosi_cap = {mosi_cap[14:0], bus.MOSI};
            adc_rx   = {adc_rx[14:0], bus.MOSI};
            t_prev   = t_last;
            t_last   = $time;
        end
    end

    task automatic start_frame(input logic [15:0] c);
        @(negedge clk);
        bus.wrt = 1'b1;
        bus.cmd = c;
        @(negedge clk);
        bus.wrt = 1'b0;
        bus.cmd = 16'h0000;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    logic [15:0] adc_cmds [4] = '{16'h2800, 16'h2800, 16'h2000, 16'h2000};
    logic [15:0] adc_exp  [4] = '{16'h0C00, 16'h0C05, 16'h0BF5, 16'h0BF4};
    int base;

    initial begin
        rst_n   = 1'b0;
        loop    = 1'b0;
        bus.wrt = 1'b0;
        bus.cmd = 16'h0000;

        repeat (2) @(negedge clk);
        chk("rst_ss_n", {31'd0, bus.SS_n}, 32'd1);
        chk("rst_sclk", {31'd0, bus.SCLK}, 32'd1);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_rd",   {16'd0, bus.rd_data}, 32'h0000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_ss_n", {31'd0, bus.SS_n}, 32'd1);
        chk("idle_sclk", {31'd0, bus.SCLK}, 32'd1);
        chk("idle_done", {31'd0, bus.done}, 32'd0);

        // ADC channel pipeline
        for (int k = 0; k < 4; k++) begin
            start_frame(adc_cmds[k]);
            wait_done($sformatf("adc%0d_done", k));
            chk($sformatf("adc%0d_rd", k), {16'd0, bus.rd_data}, {16'd0, adc_exp[k]});
        end

        // Loopback, 16 rises, SCLK period
        loop = 1'b1;
        base = rise_cnt;
        start_frame(16'hA5C3);
        wait_done("loop_done");
        chk("loop_rd",     {16'd0, bus.rd_data}, 32'h0000A5C3);
        chk("loop_rises",  rise_cnt - base, 32'd16);
        chk("loop_period", 32'(t_last - t_prev), 32'd320);

        // Busy protection
        start_frame(16'h3C5A);
        repeat (100) @(negedge clk);
        bus.wrt = 1'b1;
        bus.cmd = 16'hFFFF;
        @(negedge clk);
        bus.wrt = 1'b0;
        bus.cmd = 16'h0000;
        wait_done("busy_done");
        chk("busy_rd",   {16'd0, bus.rd_data}, 32'h00003C5A);
        chk("busy_mosi", {16'd0, mosi_cap},    32'h00003C5A);

        // Abort mid-SHIFT
        start_frame(16'h5A5A);
        repeat (150) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ss_n", {31'd0, bus.SS_n}, 32'd1);
        chk("abort_sclk", {31'd0, bus.SCLK}, 32'd1);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = rise_cnt;
        start_frame(16'h1234);
        wait_done("post_abort_done");
        chk("post_abort_rd",    {16'd0, bus.rd_data}, 32'h00001234);
        chk("post_abort_rises", rise_cnt - base, 32'd16);

        // Sticky done
        repeat (50) @(negedge clk);
        chk("sticky_done", {31'd0, bus.done}, 32'd1);
        @(negedge clk);
        bus.wrt = 1'b1;
        bus.cmd = 16'h0F0F;
        chk("done_before_acc", {31'd0, bus.done}, 32'd1);
        @(negedge clk);
        bus.wrt = 1'b0;
        bus.cmd = 16'h0000;
        chk("done_cleared", {31'd0, bus.done}, 32'd0);
        chk("ss_low",       {31'd0, bus.SS_n}, 32'd0);
        wait_done("last_done");
        chk("last_rd", {16'd0, bus.rd_data}, 32'h00000F0F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
